// File: rtl/instr_fetch_if.sv
// instr_fetch_if: imem fetch port, redirect/halt control and the decode handshake
interface instr_fetch_if #(
  parameter int N    = 32,
  parameter int PC_W = 64
);
  logic [7:0]      imem_addr;
  logic [N-1:0]    imem_q;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            halt;
  logic            if_valid;
  logic [N-1:0]    if_instr;
  logic [PC_W-1:0] if_pc;
  logic            id_ready;
  logic            fetch_idle;
  modport master (
    output imem_addr, if_valid, if_instr, if_pc, fetch_idle,
    input  imem_q, redirect_valid, redirect_pc, halt, id_ready
  );
  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, fetch_idle,
    output imem_q, redirect_valid, redirect_pc, halt, id_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC register plus a small circular queue of {pc,instr} feeding decode
module instr_fetch #(
  parameter int              N        = 32,
  parameter int              PC_W     = 64,
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           reset,
  instr_fetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pcs_q [DEPTH];
  logic [N-1:0]    ins_q [DEPTH];
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            empty, deq, enq;
  assign empty          = cnt_q == '0;
  assign deq            = !empty && bus.id_ready;
  assign enq            = !bus.halt && !bus.redirect_valid && (cnt_q < CW'(DEPTH) || deq);
  assign bus.imem_addr  = pc_q[9:2];
  assign bus.if_valid   = !empty;
  assign bus.if_instr   = empty ? '0 : ins_q[rd_q];
  assign bus.if_pc      = empty ? '0 : pcs_q[rd_q];
  assign bus.fetch_idle = empty && bus.halt;
  // next PC, pointers and occupancy; a redirect flushes and discards any same-cycle dequeue
  always_comb begin
    pc_d  = bus.redirect_valid ? (bus.redirect_pc & ~PC_W'(3)) : enq ? pc_q + PC_W'(4) : pc_q;
    rd_d  = bus.redirect_valid ? '0 : deq ? rd_q + AW'(1) : rd_q;
    wr_d  = bus.redirect_valid ? '0 : enq ? wr_q + AW'(1) : wr_q;
    cnt_d = bus.redirect_valid ? '0 : cnt_q + CW'(enq) - CW'(deq);
  end
  // control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  // queue storage; entries are only read while counted, so no reset needed
  always_ff @(posedge clk) begin
    if (enq && !reset) begin
      pcs_q[wr_q] <= pc_q;
      ins_q[wr_q] <= bus.imem_q;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scenario and randomized checks of instr_fetch against a queue-based model
module tb_instr_fetch;
  logic clk, reset;
  logic [31:0] imem [256];
  instr_fetch_if #(.N(32), .PC_W(64)) bus ();
  instr_fetch #(.N(32), .PC_W(64), .DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  assign bus.imem_q = imem[bus.imem_addr];
  typedef struct {logic [63:0] pc; logic [31:0] ins;} ent_t;
  ent_t        mq [$];
  logic [63:0] mpc;
  int vecs = 0, errs = 0;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic tick();
    bit d, e;
    @(posedge clk);
    d = mq.size() > 0 && bus.id_ready;
    e = !bus.halt && !bus.redirect_valid && (mq.size() < 2 || d);
    if (reset) begin
      mq.delete();
      mpc = 0;
    end else if (bus.redirect_valid) begin
      mq.delete();
      mpc = {bus.redirect_pc[63:2], 2'b00};
    end else begin
      if (d) void'(mq.pop_front());
      if (e) begin
        mq.push_back('{pc: mpc, ins: imem[mpc[9:2]]});
        mpc = mpc + 64'd4;
      end
    end
    #1;
  endtask
  task automatic test_reset();
    reset = 1; bus.id_ready = 1; tick();
    vecs++; if (bus.if_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %0b want 0", bus.if_valid); end
    vecs++; if (bus.if_pc !== 64'd0 || bus.if_instr !== 32'd0) begin errs++; $display("FAIL reset_head got %h/%h want 0/0", bus.if_pc, bus.if_instr); end
    vecs++; if (bus.imem_addr !== 8'd0 || bus.fetch_idle !== 1'b0) begin errs++; $display("FAIL reset_addr got %0d/%0b want 0/0", bus.imem_addr, bus.fetch_idle); end
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'(4 * i) || bus.if_instr !== imem[i]) begin
        errs++; $display("FAIL stream%0d got v=%0b pc=%h ins=%h want 1 %h %h", i, bus.if_valid, bus.if_pc, bus.if_instr, 4 * i, imem[i]);
      end
    end
  endtask
  task automatic test_backpressure();
    reset = 1; bus.id_ready = 0; tick();
    reset = 0;
    repeat (4) tick();
    vecs++; if (bus.imem_addr !== 8'd2 || bus.if_pc !== 64'd0) begin errs++; $display("FAIL bp_hold got addr=%0d pc=%h want 2 0", bus.imem_addr, bus.if_pc); end
    bus.id_ready = 1;
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'(4 * i) || bus.if_instr !== imem[i]) begin
        errs++; $display("FAIL bp_drain%0d got v=%0b pc=%h ins=%h want 1 %h %h", i, bus.if_valid, bus.if_pc, bus.if_instr, 4 * i, imem[i]);
      end
      tick();
    end
  endtask
  task automatic test_redirect();
    reset = 1; bus.id_ready = 0; tick();
    reset = 0; repeat (3) tick();
    bus.redirect_valid = 1; bus.redirect_pc = 64'h1b0; tick();
    bus.redirect_valid = 0;
    vecs++; if (bus.if_valid !== 1'b0 || bus.imem_addr !== 8'd108) begin errs++; $display("FAIL redir_flush got v=%0b addr=%0d want 0 108", bus.if_valid, bus.imem_addr); end
    tick();
    vecs++; if (bus.if_pc !== 64'h1b0 || bus.if_instr !== 32'hf4010113) begin errs++; $display("FAIL redir_first got %h/%h want 1b0/f4010113", bus.if_pc, bus.if_instr); end
    bus.id_ready = 1; tick();
    vecs++; if (bus.if_pc !== 64'h1b4 || bus.if_instr !== 32'h0a113c23) begin errs++; $display("FAIL redir_second got %h/%h want 1b4/0a113c23", bus.if_pc, bus.if_instr); end
  endtask
  task automatic test_alias_wrap();
    bus.id_ready = 0; bus.redirect_valid = 1; bus.redirect_pc = 64'h3fe; tick();
    bus.redirect_valid = 0;
    vecs++; if (bus.imem_addr !== 8'd255) begin errs++; $display("FAIL wrap_addr got %0d want 255", bus.imem_addr); end
    tick();
    vecs++; if (bus.if_pc !== 64'h3fc || bus.if_instr !== 32'h00000013 || bus.imem_addr !== 8'd0) begin errs++; $display("FAIL wrap_head got %h/%h/%0d want 3fc/00000013/0", bus.if_pc, bus.if_instr, bus.imem_addr); end
    bus.id_ready = 1; tick();
    vecs++; if (bus.if_pc !== 64'h400 || bus.if_instr !== 32'h00003197) begin errs++; $display("FAIL wrap_next got %h/%h want 400/00003197", bus.if_pc, bus.if_instr); end
  endtask
  task automatic test_halt();
    bus.id_ready = 0; bus.redirect_valid = 1; bus.redirect_pc = 64'h60; tick();
    bus.redirect_valid = 0; tick(); tick();
    bus.halt = 1; bus.id_ready = 1;
    tick();
    vecs++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h64) begin errs++; $display("FAIL halt_drain got v=%0b pc=%h want 1 64", bus.if_valid, bus.if_pc); end
    tick();
    vecs++; if (bus.fetch_idle !== 1'b1 || bus.if_valid !== 1'b0 || bus.imem_addr !== 8'd26) begin errs++; $display("FAIL halt_idle got idle=%0b v=%0b addr=%0d want 1 0 26", bus.fetch_idle, bus.if_valid, bus.imem_addr); end
    repeat (2) tick();
    vecs++; if (bus.imem_addr !== 8'd26 || bus.if_valid !== 1'b0) begin errs++; $display("FAIL halt_hold got addr=%0d v=%0b want 26 0", bus.imem_addr, bus.if_valid); end
    bus.halt = 0; tick();
    vecs++; if (bus.if_pc !== 64'h68 || bus.if_instr !== 32'h00100073) begin errs++; $display("FAIL halt_resume got %h/%h want 68/00100073", bus.if_pc, bus.if_instr); end
  endtask
  task automatic test_reset_beats_redirect();
    reset = 1; bus.id_ready = 0; tick();
    reset = 0; repeat (3) tick();
    reset = 1; bus.redirect_valid = 1; bus.redirect_pc = 64'h1b0; tick();
    vecs++; if (bus.if_valid !== 1'b0 || bus.imem_addr !== 8'd0) begin errs++; $display("FAIL rst_redir got v=%0b addr=%0d want 0 0", bus.if_valid, bus.imem_addr); end
    reset = 0; bus.redirect_valid = 0; bus.id_ready = 1; tick();
    vecs++; if (bus.if_pc !== 64'd0 || bus.if_instr !== 32'h00003197) begin errs++; $display("FAIL rst_restart got %h/%h want 0/00003197", bus.if_pc, bus.if_instr); end
  endtask
  task automatic test_back_to_back();
    reset = 1; bus.id_ready = 1; tick();
    reset = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      vecs++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'(4 * i)) begin
        errs++; $display("FAIL b2b%0d got v=%0b pc=%h want 1 %h", i, bus.if_valid, bus.if_pc, 4 * i);
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset              = $urandom_range(99) < 2;
      bus.redirect_valid = $urandom_range(99) < 5;
      bus.redirect_pc    = {$urandom, $urandom};
      bus.halt           = $urandom_range(99) < 15;
      bus.id_ready       = $urandom_range(99) < 70;
      tick();
      vecs++;
      if (bus.if_valid !== (mq.size() > 0) || bus.imem_addr !== mpc[9:2] || bus.fetch_idle !== (mq.size() == 0 && bus.halt) ||
          bus.if_pc !== (mq.size() > 0 ? mq[0].pc : 64'd0) || bus.if_instr !== (mq.size() > 0 ? mq[0].ins : 32'd0)) begin
        errs++;
        $display("FAIL rand%0d got v=%0b pc=%h ins=%h addr=%0d idle=%0b want v=%0b pc=%h ins=%h addr=%0d", i, bus.if_valid, bus.if_pc,
                 bus.if_instr, bus.imem_addr, bus.fetch_idle, mq.size() > 0, mq.size() > 0 ? mq[0].pc : 64'd0,
                 mq.size() > 0 ? mq[0].ins : 32'd0, mpc[9:2]);
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    imem[0] = 32'h00003197; imem[1] = 32'h00018193; imem[2] = 32'h00003023;
    imem[26] = 32'h00100073; imem[108] = 32'hf4010113; imem[109] = 32'h0a113c23;
    imem[255] = 32'h00000013;
    mpc = 0;
    reset = 1; bus.redirect_valid = 0; bus.redirect_pc = 0; bus.halt = 0; bus.id_ready = 0;
    test_reset();
    test_backpressure();
    test_redirect();
    test_alias_wrap();
    test_halt();
    test_reset_beats_redirect();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
